// File: rtl/muxn_pkg.sv
// Shared constants for the registered N:1 word multiplexer.
package muxn_pkg;

    localparam logic MUXN_MODE_FIXED = 1'b0;
    localparam logic MUXN_MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping mod N_IN.
module rr_pick #(
    parameter int N_IN  = 16,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int j;

    // Scan from farthest to nearest so the nearest hit is the last assignment and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_IN) j = j - N_IN;
            if (req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/muxn_1_reg.sv
// Registered N:1 valid/ready word mux with fixed-select or round-robin arbitration.
// Optional: define MUXN_OUT_CHAN_EN to add the registered out_chan port.
module muxn_1_reg
    import muxn_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int WIDTH = 16,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUXN_OUT_CHAN_EN
    ,
    output logic [SEL_W-1:0]      out_chan
`endif
);

    logic [WIDTH-1:0] chan_data [N_IN];
    logic [SEL_W-1:0] rr_ptr;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             fixed_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             can_load;
    logic             transfer;

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(.N_IN(N_IN), .SEL_W(SEL_W)) u_rr_pick (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Out-of-range select never grants, even when N_IN is not a power of two.
    assign fixed_valid = (int'(sel) < N_IN) && in_valid[sel];
    assign grant_valid = (mode == MUXN_MODE_RR) ? rr_valid : fixed_valid;
    assign grant_idx   = (mode == MUXN_MODE_RR) ? rr_idx : sel;
    assign can_load    = !out_valid || out_ready;
    assign transfer    = !rst && grant_valid && can_load;

    always_comb begin
        in_ready = '0;
        if (transfer) in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (transfer) begin
                out_data  <= chan_data[grant_idx];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (transfer && mode == MUXN_MODE_RR)
                rr_ptr <= (int'(grant_idx) == N_IN - 1) ? '0 : grant_idx + SEL_W'(1);
        end
    end

`ifdef MUXN_OUT_CHAN_EN
    always_ff @(posedge clk) begin
        if (rst)           out_chan <= '0;
        else if (transfer) out_chan <= grant_idx;
    end
`endif

endmodule

// File: tb/tb_muxn_1_reg.sv
// Directed self-checking bench for muxn_1_reg (16-channel main instance, 12-channel range instance).
module tb_muxn_1_reg;

    logic          clk = 1'b0;
    logic          rst;
    logic [255:0]  in_data;
    logic [15:0]   in_valid;
    logic [15:0]   in_ready;
    logic          mode;
    logic [3:0]    sel;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;

    logic [191:0]  in_data12;
    logic [11:0]   in_valid12;
    logic [11:0]   in_ready12;
    logic          mode12;
    logic [3:0]    sel12;
    logic [15:0]   out_data12;
    logic          out_valid12;
    logic          out_ready12;

`ifdef MUXN_OUT_CHAN_EN
    logic [3:0]    out_chan;
    logic [3:0]    out_chan12;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muxn_1_reg #(.N_IN(16), .WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUXN_OUT_CHAN_EN
        ,
        .out_chan  (out_chan)
`endif
    );

    muxn_1_reg #(.N_IN(12), .WIDTH(16)) dut12 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data12),
        .in_valid  (in_valid12),
        .in_ready  (in_ready12),
        .mode      (mode12),
        .sel       (sel12),
        .out_data  (out_data12),
        .out_valid (out_valid12),
        .out_ready (out_ready12)
`ifdef MUXN_OUT_CHAN_EN
        ,
        .out_chan  (out_chan12)
`endif
    );

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 16'hFFFF;
        out_ready = 1'b1;
        mode = 1'b0;
        sel = 4'd0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid c%0d: got %b want 0", c, out_valid); end
            checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data c%0d: got %h want 0000", c, out_data); end
            checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL reset_in_ready c%0d: got %h want 0000", c, in_ready); end
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed;
        mode = 1'b0;
        sel = 4'd5;
        in_valid = 16'hFFFF;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 16'h0020) begin errors++; $display("FAIL fixed5_in_ready: got %h want 0020", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 16'h1105) begin errors++; $display("FAIL fixed5_out_data: got %h want 1105", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed5_out_valid: got %b want 1", out_valid); end
`ifdef MUXN_OUT_CHAN_EN
        checks++; if (out_chan !== 4'd5) begin errors++; $display("FAIL fixed5_out_chan: got %0d want 5", out_chan); end
`endif
        sel = 4'd15;
        #1;
        checks++; if (in_ready !== 16'h8000) begin errors++; $display("FAIL fixed15_in_ready: got %h want 8000", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 16'h110F) begin errors++; $display("FAIL fixed15_out_data: got %h want 110f", out_data); end
    endtask

    task automatic test_no_grant;
        sel = 4'd3;
        in_valid = 16'hFFF7;
        #1;
        checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL nogrant_in_ready: got %h want 0000", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nogrant_drain_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h110F) begin errors++; $display("FAIL nogrant_hold_data: got %h want 110f", out_data); end

        sel12 = 4'd13;
        in_valid12 = 12'hFFF;
        #1;
        checks++; if (in_ready12 !== 12'h000) begin errors++; $display("FAIL n12_sel13_in_ready: got %h want 000", in_ready12); end
        @(posedge clk); #1;
        checks++; if (out_valid12 !== 1'b0) begin errors++; $display("FAIL n12_sel13_out_valid: got %b want 0", out_valid12); end
        sel12 = 4'd11;
        #1;
        checks++; if (in_ready12 !== 12'h800) begin errors++; $display("FAIL n12_sel11_in_ready: got %h want 800", in_ready12); end
        @(posedge clk); #1;
        checks++; if (out_data12 !== 16'h220B) begin errors++; $display("FAIL n12_sel11_out_data: got %h want 220b", out_data12); end
        checks++; if (out_valid12 !== 1'b1) begin errors++; $display("FAIL n12_sel11_out_valid: got %b want 1", out_valid12); end
    endtask

    task automatic test_round_robin;
        int          exp_g [6] = '{0, 5, 10, 15, 0, 5};
        logic [15:0] exp_rdy;
        logic [15:0] exp_dat;
        mode = 1'b1;
        in_valid = 16'h8421;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            exp_rdy = 16'h0001 << exp_g[n];
            exp_dat = 16'h1100 | 16'(exp_g[n]);
            #1;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr_in_ready n%0d: got %h want %h", n, in_ready, exp_rdy); end
            @(posedge clk); #1;
            checks++; if (out_data !== exp_dat) begin errors++; $display("FAIL rr_out_data n%0d: got %h want %h", n, out_data, exp_dat); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_out_valid n%0d: got %b want 1", n, out_valid); end
        end
    endtask

    task automatic test_back_pressure;
        mode = 1'b0;
        sel = 4'd2;
        in_valid = 16'hFFFF;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 16'h0004) begin errors++; $display("FAIL bp_load_in_ready: got %h want 0004", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 16'h1102) begin errors++; $display("FAIL bp_load_out_data: got %h want 1102", out_data); end
        out_ready = 1'b0;
        sel = 4'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL bp_stall_in_ready c%0d: got %h want 0000", c, in_ready); end
            checks++; if (out_data !== 16'h1102) begin errors++; $display("FAIL bp_stall_out_data c%0d: got %h want 1102", c, out_data); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_out_valid c%0d: got %b want 1", c, out_valid); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 16'h0080) begin errors++; $display("FAIL bp_release_in_ready: got %h want 0080", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 16'h1107) begin errors++; $display("FAIL bp_release_out_data: got %h want 1107", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_out_valid: got %b want 1", out_valid); end
    endtask

    task automatic test_reset_midstream;
        // Pointer sits at 6 after the round-robin sequence; granting 6 moves it to 7.
        mode = 1'b1;
        in_valid = 16'h0040;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 16'h0040) begin errors++; $display("FAIL mid_pre_in_ready: got %h want 0040", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 16'h1106) begin errors++; $display("FAIL mid_pre_out_data: got %h want 1106", out_data); end
        in_valid = 16'h0208;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 16'h0000) begin errors++; $display("FAIL mid_rst_in_ready: got %h want 0000", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_out_data: got %h want 0000", out_data); end
`ifdef MUXN_OUT_CHAN_EN
        checks++; if (out_chan !== 4'd0) begin errors++; $display("FAIL mid_rst_out_chan: got %0d want 0", out_chan); end
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 16'h0008) begin errors++; $display("FAIL mid_post_in_ready: got %h want 0008", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== 16'h1103) begin errors++; $display("FAIL mid_post_out_data: got %h want 1103", out_data); end
`ifdef MUXN_OUT_CHAN_EN
        checks++; if (out_chan !== 4'd3) begin errors++; $display("FAIL mid_post_out_chan: got %0d want 3", out_chan); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) in_data[i*16 +: 16] = 16'h1100 | 16'(i);
        for (int i = 0; i < 12; i++) in_data12[i*16 +: 16] = 16'h2200 | 16'(i);
        in_valid12 = '0;
        mode12 = 1'b0;
        sel12 = 4'd0;
        out_ready12 = 1'b1;

        test_reset();
        test_fixed();
        test_no_grant();
        test_round_robin();
        test_back_pressure();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
